// File: rtl/bp_be_late_wb_queue_pkg.sv
// rtl/bp_be_late_wb_queue_pkg.sv - writeback packet type shared by the late-writeback queue
package bp_be_late_wb_queue_pkg;

  localparam int reg_addr_width_gp = 5;
  localparam int dword_width_gp    = 64;
  localparam int fflags_width_gp   = 5;

  // Long-latency register result as seen by the scheduler.
  typedef struct packed {
    logic                         ird_w_v;
    logic                         frd_w_v;
    logic [reg_addr_width_gp-1:0] rd_addr;
    logic [dword_width_gp-1:0]    rd_data;
    logic                         fflags_w_v;
    logic [fflags_width_gp-1:0]   fflags;
  } bp_be_wb_pkt_s;

  localparam int wb_pkt_width_lp = $bits(bp_be_wb_pkt_s);

endpackage

// File: rtl/bp_be_late_wb_ring.sv
// rtl/bp_be_late_wb_ring.sv - 2-write/1-read circular buffer with occupancy count
module bp_be_late_wb_ring #(
  parameter  int els_p     = 4,
  parameter  int width_p   = 8,
  localparam int ptr_w_lp  = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int cnt_w_lp  = $clog2(els_p + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w0_v,
  input  logic [width_p-1:0]  w0_data,
  input  logic                w1_v,
  input  logic [width_p-1:0]  w1_data,
  input  logic                deq,
  output logic [width_p-1:0]  data,
  output logic [cnt_w_lp-1:0] count
);

  logic [width_p-1:0]  mem [els_p];
  logic [ptr_w_lp-1:0] rptr_r, wptr_r, wptr_p1, w1_addr;
  logic [cnt_w_lp-1:0] count_r;

  // Pointers wrap modulo els_p, so depth need not be a power of two.
  function automatic logic [ptr_w_lp-1:0] wrap_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wptr_p1 = wrap_inc(wptr_r);
  // The second write lands behind the first when both arrive together.
  assign w1_addr = w0_v ? wptr_p1 : wptr_r;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w0_v) mem[wptr_r]  <= w0_data;
    if (w1_v) mem[w1_addr] <= w1_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (deq) rptr_r <= wrap_inc(rptr_r);
      case ({w0_v, w1_v})
        2'b11:        wptr_r <= wrap_inc(wptr_p1);
        2'b10, 2'b01: wptr_r <= wptr_p1;
        default:      wptr_r <= wptr_r;
      endcase
      count_r <= count_r + cnt_w_lp'(w0_v) + cnt_w_lp'(w1_v) - cnt_w_lp'(deq);
    end
  end

  assign data  = mem[rptr_r];
  assign count = count_r;

endmodule

// File: rtl/bp_be_late_wb_queue.sv
// rtl/bp_be_late_wb_queue.sv - merges int and fp late results toward the scheduler with starvation force
module bp_be_late_wb_queue
  import bp_be_late_wb_queue_pkg::*;
#(
  parameter  int els_p    = 4,
  parameter  int starve_p = 16,
  localparam int cnt_w_lp = $clog2(els_p + 1),
  localparam int age_w_lp = $clog2(starve_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [wb_pkt_width_lp-1:0] int_wb_pkt_i,
  input  logic                       int_wb_v_i,
  output logic                       int_wb_ready_and_o,
  input  logic [wb_pkt_width_lp-1:0] fp_wb_pkt_i,
  input  logic                       fp_wb_v_i,
  output logic                       fp_wb_ready_and_o,
  output logic [wb_pkt_width_lp-1:0] late_wb_pkt_o,
  output logic                       late_wb_v_o,
  output logic                       late_wb_force_o,
  input  logic                       late_wb_yumi_i,
  output logic                       empty_o,
  output logic [cnt_w_lp-1:0]        count_o
);

  localparam logic [cnt_w_lp-1:0] full_c    = cnt_w_lp'(els_p);
  localparam logic [cnt_w_lp-1:0] one_free_c = cnt_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] two_free_c = cnt_w_lp'(els_p - 2);
  localparam logic [age_w_lp-1:0] starve_c  = age_w_lp'(starve_p);

  logic [cnt_w_lp-1:0] count_r;
  logic [age_w_lp-1:0] age_r;
  logic                int_enq, fp_enq, deq;

  // Readys look only at registered occupancy so yumi never feeds them;
  // int wins the last free slot.
  assign int_wb_ready_and_o = (count_r <= one_free_c);
  assign fp_wb_ready_and_o  = (count_r <= two_free_c) | ((count_r == one_free_c) & ~int_wb_v_i);

  assign int_enq = int_wb_v_i & int_wb_ready_and_o;
  assign fp_enq  = fp_wb_v_i & fp_wb_ready_and_o;
  assign deq     = late_wb_yumi_i & late_wb_v_o;

  bp_be_late_wb_ring #(
    .els_p   (els_p),
    .width_p (wb_pkt_width_lp)
  ) ring (
    .clk     (clk_i),
    .rst     (reset_i),
    .w0_v    (int_enq),
    .w0_data (int_wb_pkt_i),
    .w1_v    (fp_enq),
    .w1_data (fp_wb_pkt_i),
    .deq     (deq),
    .data    (late_wb_pkt_o),
    .count   (count_r)
  );

  assign late_wb_v_o = (count_r != '0);
  assign empty_o     = (count_r == '0);
  assign count_o     = count_r;

  // Head age: counts cycles the head sits unconsumed, saturating so force holds until yumi.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                              age_r <= '0;
    else if (late_wb_yumi_i | ~late_wb_v_o)   age_r <= '0;
    else if (age_r != starve_c)               age_r <= age_r + 1'b1;
  end

  assign late_wb_force_o = late_wb_v_o & ((count_r == full_c) | (age_r == starve_c));

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    late_wb_yumi_i |-> late_wb_v_o);

  count_bounded: assert property (@(posedge clk_i) disable iff (reset_i)
    count_r <= full_c);

  force_honored: assert property (@(posedge clk_i) disable iff (reset_i)
    (late_wb_force_o & ~late_wb_yumi_i) |=> late_wb_yumi_i);

endmodule

// File: tb/tb_bp_be_late_wb_queue.sv
// tb/tb_bp_be_late_wb_queue.sv - directed self-checking bench for bp_be_late_wb_queue
module tb_bp_be_late_wb_queue;
  import bp_be_late_wb_queue_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance a: depth 4, starve 16
  bp_be_wb_pkt_s               a_int_pkt, a_fp_pkt;
  logic                        a_int_v, a_fp_v, a_yumi;
  logic                        a_int_rdy, a_fp_rdy, a_v, a_force, a_empty;
  logic [wb_pkt_width_lp-1:0]  a_pkt;
  logic [2:0]                  a_count;

  // Instance b: depth 3 for pointer wrap
  bp_be_wb_pkt_s               b_int_pkt, b_fp_pkt;
  logic                        b_int_v, b_fp_v, b_yumi;
  logic                        b_int_rdy, b_fp_rdy, b_v, b_force, b_empty;
  logic [wb_pkt_width_lp-1:0]  b_pkt;
  logic [1:0]                  b_count;

  bp_be_late_wb_queue #(.els_p(4), .starve_p(16)) dut_a (
    .clk_i              (clk),
    .reset_i            (reset),
    .int_wb_pkt_i       (a_int_pkt),
    .int_wb_v_i         (a_int_v),
    .int_wb_ready_and_o (a_int_rdy),
    .fp_wb_pkt_i        (a_fp_pkt),
    .fp_wb_v_i          (a_fp_v),
    .fp_wb_ready_and_o  (a_fp_rdy),
    .late_wb_pkt_o      (a_pkt),
    .late_wb_v_o        (a_v),
    .late_wb_force_o    (a_force),
    .late_wb_yumi_i     (a_yumi),
    .empty_o            (a_empty),
    .count_o            (a_count)
  );

  bp_be_late_wb_queue #(.els_p(3), .starve_p(16)) dut_b (
    .clk_i              (clk),
    .reset_i            (reset),
    .int_wb_pkt_i       (b_int_pkt),
    .int_wb_v_i         (b_int_v),
    .int_wb_ready_and_o (b_int_rdy),
    .fp_wb_pkt_i        (b_fp_pkt),
    .fp_wb_v_i          (b_fp_v),
    .fp_wb_ready_and_o  (b_fp_rdy),
    .late_wb_pkt_o      (b_pkt),
    .late_wb_v_o        (b_v),
    .late_wb_force_o    (b_force),
    .late_wb_yumi_i     (b_yumi),
    .empty_o            (b_empty),
    .count_o            (b_count)
  );

  int passed = 0;
  int total  = 0;

  function automatic bp_be_wb_pkt_s ipkt(input logic [4:0] rd);
    bp_be_wb_pkt_s p;
    p = '0;
    p.ird_w_v = 1'b1;
    p.rd_addr = rd;
    p.rd_data = {32'hCAFE0000, 27'd0, rd};
    return p;
  endfunction

  function automatic bp_be_wb_pkt_s fpkt(input logic [4:0] rd);
    bp_be_wb_pkt_s p;
    p = '0;
    p.frd_w_v    = 1'b1;
    p.rd_addr    = rd;
    p.rd_data    = {32'h3FF00000, 27'd0, rd};
    p.fflags_w_v = 1'b1;
    p.fflags     = rd ^ 5'h1F;
    return p;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs are then changed 2 time units past the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bp_be_wb_pkt_s exp_q [4];

    reset = 1'b1;
    a_int_v = 1'b1; a_int_pkt = ipkt(5'd9);
    a_fp_v = 1'b0;  a_fp_pkt = '0;  a_yumi = 1'b0;
    b_int_v = 1'b0; b_int_pkt = '0;
    b_fp_v = 1'b0;  b_fp_pkt = '0;  b_yumi = 1'b0;
    #1;
    check("rst_v_early", a_v, 1'b0);

    // Reset held with int valid: nothing may enqueue
    cyc(); cyc();
    check("rst_v", a_v, 1'b0);
    check("rst_count", a_count, 3'd0);
    check("rst_empty", a_empty, 1'b1);
    check("rst_force", a_force, 1'b0);
    check("rst_int_rdy", a_int_rdy, 1'b1);
    check("rst_fp_rdy", a_fp_rdy, 1'b1);
    check("rst_b_empty", b_empty, 1'b1);
    reset = 1'b0;
    #1;
    check("post_rst_count", a_count, 3'd0);
    cyc();
    a_int_v = 1'b0;
    #1;
    check("first_enq_count", a_count, 3'd1);
    check("first_enq_head", a_pkt, ipkt(5'd9));
    a_yumi = 1'b1;
    cyc();
    a_yumi = 1'b0;
    #1;
    check("drain0_empty", a_empty, 1'b1);

    // Starvation: int 5 then fp 7, no yumi until force
    a_int_v = 1'b1; a_int_pkt = ipkt(5'd5);
    cyc();
    a_int_v = 1'b0;
    a_fp_v = 1'b1; a_fp_pkt = fpkt(5'd7);
    cyc();
    a_fp_v = 1'b0;
    #1;
    check("age1_force", a_force, 1'b0);
    check("age1_count", a_count, 3'd2);
    repeat (14) cyc();
    #1;
    check("age15_force", a_force, 1'b0);
    cyc();
    #1;
    check("age16_force", a_force, 1'b1);
    check("age16_head", a_pkt, ipkt(5'd5));
    a_yumi = 1'b1;
    cyc();
    a_yumi = 1'b0;
    #1;
    check("after_yumi_head", a_pkt, fpkt(5'd7));
    check("after_yumi_force", a_force, 1'b0);
    check("after_yumi_count", a_count, 3'd1);
    a_yumi = 1'b1;
    cyc();
    a_yumi = 1'b0;
    #1;
    check("drain1_empty", a_empty, 1'b1);

    // Dual enqueue at empty, back-to-back dequeue
    a_int_v = 1'b1; a_int_pkt = ipkt(5'd1);
    a_fp_v = 1'b1;  a_fp_pkt = fpkt(5'd2);
    #1;
    check("dual_int_rdy", a_int_rdy, 1'b1);
    check("dual_fp_rdy", a_fp_rdy, 1'b1);
    cyc();
    a_int_v = 1'b0; a_fp_v = 1'b0;
    #1;
    check("dual_count", a_count, 3'd2);
    check("dual_head0", a_pkt, ipkt(5'd1));
    a_yumi = 1'b1;
    cyc();
    #1;
    check("dual_head1", a_pkt, fpkt(5'd2));
    check("dual_v_nobubble", a_v, 1'b1);
    cyc();
    a_yumi = 1'b0;
    #1;
    check("dual_empty", a_empty, 1'b1);

    // Fill to 4
    a_int_v = 1'b1; a_int_pkt = ipkt(5'd10);
    a_fp_v = 1'b1;  a_fp_pkt = fpkt(5'd11);
    cyc();
    a_int_pkt = ipkt(5'd12);
    a_fp_pkt = fpkt(5'd13);
    #1;
    check("fill2_fp_rdy", a_fp_rdy, 1'b1);
    cyc();
    a_int_v = 1'b0; a_fp_v = 1'b0;
    #1;
    check("full_count", a_count, 3'd4);
    check("full_int_rdy", a_int_rdy, 1'b0);
    check("full_fp_rdy", a_fp_rdy, 1'b0);
    check("full_force", a_force, 1'b1);

    // Yumi and int valid together while full: int waits one cycle
    a_yumi = 1'b1;
    a_int_v = 1'b1; a_int_pkt = ipkt(5'd14);
    #1;
    check("full_yumi_int_rdy", a_int_rdy, 1'b0);
    cyc();
    a_yumi = 1'b0;
    #1;
    check("freed_count", a_count, 3'd3);
    check("freed_head", a_pkt, fpkt(5'd11));
    check("freed_int_rdy", a_int_rdy, 1'b1);
    cyc();
    a_int_v = 1'b0;
    #1;
    check("refill_count", a_count, 3'd4);
    a_yumi = 1'b1;
    cyc();
    a_yumi = 1'b0;

    // count 3, both valid: int wins last slot, fp held
    a_int_v = 1'b1; a_int_pkt = ipkt(5'd20);
    a_fp_v = 1'b1;  a_fp_pkt = fpkt(5'd21);
    #1;
    check("c3_count", a_count, 3'd3);
    check("c3_int_rdy", a_int_rdy, 1'b1);
    check("c3_fp_rdy", a_fp_rdy, 1'b0);
    cyc();
    a_int_v = 1'b0;
    #1;
    check("c3_after_count", a_count, 3'd4);
    check("c3_after_fp_rdy", a_fp_rdy, 1'b0);
    a_yumi = 1'b1;
    cyc();
    a_yumi = 1'b0;
    #1;
    check("fp_retry_rdy", a_fp_rdy, 1'b1);
    cyc();
    a_fp_v = 1'b0;
    #1;
    check("fp_retry_count", a_count, 3'd4);

    exp_q[0] = fpkt(5'd13);
    exp_q[1] = ipkt(5'd14);
    exp_q[2] = ipkt(5'd20);
    exp_q[3] = fpkt(5'd21);
    a_yumi = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("drain_head%0d", i), a_pkt, exp_q[i]);
      cyc();
    end
    a_yumi = 1'b0;
    #1;
    check("drain_final_empty", a_empty, 1'b1);

    // Depth-3 instance: steady enqueue+dequeue at count 1 across pointer wrap
    b_int_v = 1'b1; b_int_pkt = ipkt(5'd0);
    cyc();
    b_int_v = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k % 2 == 1) begin
        b_fp_v = 1'b1; b_fp_pkt = fpkt(5'(k));
      end else begin
        b_int_v = 1'b1; b_int_pkt = ipkt(5'(k));
      end
      b_yumi = 1'b1;
      #1;
      check($sformatf("wrap_count%0d", k), b_count, 2'd1);
      if (k % 2 == 1) check($sformatf("wrap_head%0d", k - 1), b_pkt, ipkt(5'(k - 1)));
      else            check($sformatf("wrap_head%0d", k - 1), b_pkt, fpkt(5'(k - 1)));
      cyc();
      b_int_v = 1'b0; b_fp_v = 1'b0;
    end
    b_yumi = 1'b0;
    #1;
    check("wrap_last_head", b_pkt, ipkt(5'd10));
    check("wrap_last_count", b_count, 2'd1);
    b_yumi = 1'b1;
    cyc();
    b_yumi = 1'b0;
    #1;
    check("wrap_empty", b_empty, 1'b1);

    // Asynchronous reset mid-operation discards entries
    a_int_v = 1'b1; a_int_pkt = ipkt(5'd3);
    cyc();
    a_int_v = 1'b0;
    #1;
    check("pre_arst_count", a_count, 3'd1);
    reset = 1'b1;
    #1;
    check("arst_count", a_count, 3'd0);
    check("arst_v", a_v, 1'b0);
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
